// File: rtl/sega_joy_reader.sv
// Two-port Sega DB9 pad reader: one scan step per hs_n falling edge,
// producing active-low 12-bit words {M,X,Y,Z,S,A,C,B,R,L,D,U} per port.
module sega_joy_reader #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        hs_n_i,
  input  logic [5:0]  joy1_pins_i,
  input  logic [5:0]  joy2_pins_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        scan_done_o
);

  typedef struct packed {
    logic [11:0] bits;
    logic        cand;
    logic        six;
  } port_t;

  localparam port_t PORT_RESET = '{bits: 12'hFFF, cand: 1'b0, six: 1'b0};

  logic [SYNC_STAGES-1:0]       hs_sync;
  logic [SYNC_STAGES-1:0][11:0] pin_sync;
  logic                         hs_prev;
  logic                         strobe;
  logic [11:0]                  pins;

  logic [7:0] step_q, step_d;
  logic       p7_q, p7_d;
  logic       done_q, done_d;
  port_t      port1_q, port1_d, port2_q, port2_d;

  assign pins   = pin_sync[SYNC_STAGES-1];
  assign strobe = !hs_sync[SYNC_STAGES-1] && hs_prev;

  // Pin bit order is {p9, p6, R, L, D, U}; the same update applies to both ports.
  function automatic port_t step_port(input logic [7:0] step, input logic [5:0] p,
                                      input port_t cur);
    port_t nxt = cur;
    case (step)
      8'd2: begin
        nxt.bits[5:0] = p;
        nxt.cand      = 1'b0;
      end
      8'd3: begin
        if (p[3:2] == 2'b00) nxt.bits[7:6] = p[5:4];
        else                 nxt.bits[7:4] = {2'b11, p[5:4]};
      end
      8'd5: if (p[3:0] == 4'h0) nxt.cand = 1'b1;
      8'd6: begin
        nxt.bits[11:8] = cur.cand ? p[3:0] : 4'hF;
        nxt.six        = cur.cand;
      end
      default: ;
    endcase
    return nxt;
  endfunction

  // NOTE: synchronizers preset to 1 (idle level) so reset release never looks like an hs_n fall.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      hs_sync  <= '1;
      pin_sync <= '1;
      hs_prev  <= 1'b1;
      step_q   <= 8'd0;
      p7_q     <= 1'b1;
      done_q   <= 1'b0;
      port1_q  <= PORT_RESET;
      port2_q  <= PORT_RESET;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of order.
      hs_sync  <= {hs_sync[SYNC_STAGES-2:0], hs_n_i};
      pin_sync <= {pin_sync[SYNC_STAGES-2:0], {joy2_pins_i, joy1_pins_i}};
      hs_prev  <= hs_sync[SYNC_STAGES-1];
      step_q   <= step_d;
      p7_q     <= p7_d;
      done_q   <= done_d;
      port1_q  <= port1_d;
      port2_q  <= port2_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first so no path leaves a variable unassigned (no latch).
    step_d  = step_q;
    p7_d    = p7_q;
    done_d  = 1'b0;
    port1_d = port1_q;
    port2_d = port2_q;
    if (strobe) begin
      step_d  = step_q + 8'd1;
      p7_d    = !(step_q inside {8'd0, 8'd2, 8'd4, 8'd6});
      done_d  = (step_q == 8'd6);
      port1_d = step_port(step_q, pins[5:0], port1_q);
      port2_d = step_port(step_q, pins[11:6], port2_q);
    end
  end

  always_comb begin
    joy_p7_o    = p7_q;
    joy1_o      = port1_q.bits;
    joy2_o      = port2_q.bits;
    six1_o      = port1_q.six;
    six2_o      = port2_q.six;
    scan_done_o = done_q;
  end

endmodule

// File: tb/tb_sega_joy_reader.sv
// Directed bench for sega_joy_reader: pad stimulus is applied per scan step
// with hand-derived expected words.
module tb_sega_joy_reader;

  logic        clk_i = 1'b0;
  logic        res_n_i;
  logic        hs_n_i;
  logic [5:0]  joy1_pins_i;
  logic [5:0]  joy2_pins_i;
  logic        joy_p7_o;
  logic [11:0] joy1_o;
  logic [11:0] joy2_o;
  logic        six1_o;
  logic        six2_o;
  logic        scan_done_o;

  int checks   = 0;
  int passes   = 0;
  int fails    = 0;
  int done_cnt = 0;
  int p7_edges = 0;
  logic p7_prev = 1'b1;

  sega_joy_reader #(.SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .res_n_i     (res_n_i),
    .hs_n_i      (hs_n_i),
    .joy1_pins_i (joy1_pins_i),
    .joy2_pins_i (joy2_pins_i),
    .joy_p7_o    (joy_p7_o),
    .joy1_o      (joy1_o),
    .joy2_o      (joy2_o),
    .six1_o      (six1_o),
    .six2_o      (six2_o),
    .scan_done_o (scan_done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (scan_done_o) done_cnt <= done_cnt + 1;
    p7_prev <= joy_p7_o;
    if (joy_p7_o != p7_prev) p7_edges <= p7_edges + 1;
  end

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One hs_n pulse with the given pad pins applied ahead of the strobe.
  task automatic step(input logic [5:0] p1, input logic [5:0] p2);
    @(negedge clk_i);
    joy1_pins_i = p1;
    joy2_pins_i = p2;
    repeat (2) @(negedge clk_i);
    hs_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    hs_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(6'h3F, 6'h3F);
  endtask

  int d0;
  int e0;

  initial begin
    res_n_i     = 1'b0;
    hs_n_i      = 1'b1;
    joy1_pins_i = 6'h00;
    joy2_pins_i = 6'h00;
    repeat (3) @(negedge clk_i);
    check("rst_joy1", joy1_o, 12'hFFF);
    check("rst_joy2", joy2_o, 12'hFFF);
    check("rst_p7", 12'(joy_p7_o), 12'h1);
    check("rst_six1", 12'(six1_o), 12'h0);
    check("rst_six2", 12'(six2_o), 12'h0);
    check("rst_done", 12'(scan_done_o), 12'h0);

    res_n_i     = 1'b1;
    joy1_pins_i = 6'b111110;
    joy2_pins_i = 6'h3F;
    repeat (4) @(negedge clk_i);

    // Step 0 with edge-by-edge latency check
    hs_n_i = 1'b0;
    @(posedge clk_i); #1 check("strobe_edge1", 12'(joy_p7_o), 12'h1);
    @(posedge clk_i); #1 check("strobe_edge2", 12'(joy_p7_o), 12'h1);
    @(posedge clk_i); #1 check("strobe_edge3", 12'(joy_p7_o), 12'h0);
    repeat (2) @(negedge clk_i);
    hs_n_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Master System pad, up pressed: steps 1..6
    d0 = done_cnt;
    for (int s = 1; s <= 5; s++) step(6'b111110, 6'h3F);
    check("sms_no_early_done", 12'(done_cnt - d0), 12'd0);
    step(6'b111110, 6'h3F);
    check("sms_done_once", 12'(done_cnt - d0), 12'd1);
    check("sms_joy1", joy1_o, 12'hFFE);
    check("sms_six1", 12'(six1_o), 12'h0);
    check("sms_joy2", joy2_o, 12'hFFF);
    idle_steps(249);

    // Port 1 MD 3-button (A+B pressed), port 2 6-button (X pressed): steps 0..6
    d0 = done_cnt;
    step(6'h3F,     6'h3F);
    step(6'b100011, 6'b110011);
    step(6'b101111, 6'b111111);
    step(6'b100011, 6'b110011);
    step(6'b101111, 6'b111111);
    step(6'b100011, 6'b110000);
    step(6'b101111, 6'b111011);
    check("md3_joy1", joy1_o, 12'hFAF);
    check("md3_joy1_ab", 12'(joy1_o[7:4]), 12'b1010);
    check("md3_six1", 12'(six1_o), 12'h0);
    check("md6_joy2", joy2_o, 12'hBFF);
    check("md6_six2", 12'(six2_o), 12'h1);
    check("md_done_once", 12'(done_cnt - d0), 12'd1);
    idle_steps(249);

    // Two complete scans: counter wraps twice
    d0 = done_cnt;
    idle_steps(512);
    check("wrap_done_two", 12'(done_cnt - d0), 12'd2);
    check("wrap_p7_high", 12'(joy_p7_o), 12'h1);
    check("wrap_joy2", joy2_o, 12'hFFF);
    check("wrap_six2", 12'(six2_o), 12'h0);
    step(6'h3F, 6'h3F);
    check("wrap_step0_p7", 12'(joy_p7_o), 12'h0);

    // hs_n held low: exactly one step (step 1 raises p7 once)
    e0 = p7_edges;
    @(negedge clk_i);
    hs_n_i = 1'b0;
    repeat (1000) @(negedge clk_i);
    check("hold_one_step", 12'(p7_edges - e0), 12'd1);
    check("hold_p7", 12'(joy_p7_o), 12'h1);
    hs_n_i = 1'b1;
    repeat (4) @(negedge clk_i);

    // Steps 2..4, then asynchronous reset during step 4
    step(6'b111110, 6'h3F);
    check("mid_step2_p7", 12'(joy_p7_o), 12'h0);
    check("mid_step2_joy1", joy1_o, 12'hFFE);
    step(6'b111110, 6'h3F);
    check("mid_step3_p7", 12'(joy_p7_o), 12'h1);
    step(6'b111110, 6'h3F);
    check("mid_step4_p7", 12'(joy_p7_o), 12'h0);
    @(negedge clk_i);
    #2 res_n_i = 1'b0;
    #1;
    check("arst_joy1", joy1_o, 12'hFFF);
    check("arst_joy2", joy2_o, 12'hFFF);
    check("arst_p7", 12'(joy_p7_o), 12'h1);
    @(negedge clk_i);
    res_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    step(6'b111110, 6'h3F);
    check("post_rst_step0_p7", 12'(joy_p7_o), 12'h0);
    check("post_rst_joy1", joy1_o, 12'hFFF);
    d0 = done_cnt;
    for (int s = 1; s <= 6; s++) step(6'b111110, 6'h3F);
    check("post_rst_done", 12'(done_cnt - d0), 12'd1);
    check("post_rst_scan_joy1", joy1_o, 12'hFFE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
